// File: rtl/calculation_unit_exponent_sequencer.sv
// Exponent-path sequencer for the calculation unit.
// It accepts one op at a time, registers the operand exponents and the
// selecter control, holds them for the op's iteration count, and then
// captures the selecter output into a result register for downstream.

package calc1;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned RES_W = 10;
  localparam int unsigned OPC_W = 3;
  localparam int unsigned CNT_W = 8;

  // Control word for the exponent selecter.
  typedef enum logic [2:0] {
    A     = 3'd0,
    B     = 3'd1,
    ADD   = 3'd2,
    SUB   = 3'd3,
    B_SHR = 3'd4
  } exponent_select;

  // Issue-stage op encodings; 5-7 are illegal.
  localparam logic [OPC_W-1:0] OP_PASS_A = 3'd0;
  localparam logic [OPC_W-1:0] OP_PASS_B = 3'd1;
  localparam logic [OPC_W-1:0] OP_MUL    = 3'd2;
  localparam logic [OPC_W-1:0] OP_DIV    = 3'd3;
  localparam logic [OPC_W-1:0] OP_SQRT   = 3'd4;

endpackage

module calculation_unit_exponent_sequencer #(
  parameter int unsigned ITER_CYCLES = 24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [calc1::OPC_W-1:0]    op_code,
  input  logic [calc1::EXP_W-1:0]    exponent_a,
  input  logic [calc1::EXP_W-1:0]    exponent_b,
  output logic [calc1::EXP_W-1:0]    aligned_exponent_a,
  output logic [calc1::EXP_W-1:0]    aligned_exponent_b,
  output calc1::exponent_select      calculation_exponent_select,
  input  logic [calc1::RES_W-1:0]    calculated_exponent,
  output logic                       busy,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [calc1::RES_W-1:0]    result_exponent,
  output logic                       result_illegal_op
);

  localparam int unsigned EXP_W = calc1::EXP_W;
  localparam int unsigned RES_W = calc1::RES_W;
  localparam int unsigned CNT_W = calc1::CNT_W;

  // Counter value for multi-cycle ops: the last iterate cycle sees zero.
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITERATE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Registered state and outputs.
  state_e                 r_state;
  logic                   r_op_ready;
  logic                   r_busy;
  logic                   r_result_valid;
  logic [EXP_W-1:0]       r_exp_a;
  logic [EXP_W-1:0]       r_exp_b;
  calc1::exponent_select  r_select;
  logic                   r_illegal;
  logic [CNT_W-1:0]       r_count;
  logic [RES_W-1:0]       r_result_exponent;
  logic                   r_result_illegal_op;

  // Combinational decode and control.
  state_e                 w_state_nxt;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_count_zero;
  calc1::exponent_select  w_sel_dec;
  logic [CNT_W-1:0]       w_cnt_dec;
  logic                   w_illegal_dec;

  assign w_count_zero = (r_count == '0);

  // Decode op_code into selecter control, iteration count and illegal flag.
  always_comb begin
    w_sel_dec     = calc1::A;
    w_cnt_dec     = '0;
    w_illegal_dec = 1'b0;
    case (op_code)
      calc1::OP_PASS_A: w_sel_dec = calc1::A;
      calc1::OP_PASS_B: w_sel_dec = calc1::B;
      calc1::OP_MUL:    w_sel_dec = calc1::ADD;
      calc1::OP_DIV: begin
        w_sel_dec = calc1::SUB;
        w_cnt_dec = ITER_LAST;
      end
      calc1::OP_SQRT: begin
        w_sel_dec = calc1::B_SHR;
        w_cnt_dec = ITER_LAST;
      end
      default: begin
        w_sel_dec     = calc1::A;
        w_illegal_dec = 1'b1;
      end
    endcase
  end

  // Next-state logic; flush outranks both accept and result hand-off.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush && op_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ITERATE;
        end
      end
      ITERATE: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (w_count_zero) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (flush || result_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register plus status outputs derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_op_ready     <= 1'b1;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_op_ready     <= (w_state_nxt == IDLE);
      r_busy         <= (w_state_nxt != IDLE);
      r_result_valid <= (w_state_nxt == DONE);
    end
  end

  // Operand exponents and selecter control change only on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exp_a   <= '0;
      r_exp_b   <= '0;
      r_select  <= calc1::A;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_exp_a   <= exponent_a;
      r_exp_b   <= exponent_b;
      r_select  <= w_sel_dec;
      r_illegal <= w_illegal_dec;
    end
  end

  // Iteration counter: loaded on accept, counts down to zero in ITERATE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_cnt_dec;
    end else if ((r_state == ITERATE) && !w_count_zero) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Result register: selecter output and illegal flag captured verbatim.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result_exponent   <= '0;
      r_result_illegal_op <= 1'b0;
    end else if (w_capture) begin
      r_result_exponent   <= calculated_exponent;
      r_result_illegal_op <= r_illegal;
    end
  end

  assign op_ready                    = r_op_ready;
  assign busy                        = r_busy;
  assign result_valid                = r_result_valid;
  assign aligned_exponent_a          = r_exp_a;
  assign aligned_exponent_b          = r_exp_b;
  assign calculation_exponent_select = r_select;
  assign result_exponent             = r_result_exponent;
  assign result_illegal_op           = r_result_illegal_op;

endmodule

// File: tb/tb_calculation_unit_exponent_sequencer.sv
// Bench for the exponent sequencer: a transaction-level model predicts the
// outputs every cycle, and directed ops pin latencies and literal results.

module tb_calculation_unit_exponent_sequencer;

  localparam int unsigned ITER = 24;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  op_valid = 1'b0;
  logic                  result_ready = 1'b0;
  logic [2:0]            op_code = 3'd0;
  logic [7:0]            exponent_a = 8'd0;
  logic [7:0]            exponent_b = 8'd0;
  logic                  op_ready;
  logic                  busy;
  logic                  result_valid;
  logic                  result_illegal_op;
  logic [7:0]            aligned_exponent_a;
  logic [7:0]            aligned_exponent_b;
  calc1::exponent_select calculation_exponent_select;
  logic [9:0]            calculated_exponent;
  logic [9:0]            result_exponent;

  int n_tests = 0;
  int n_fail  = 0;

  calculation_unit_exponent_sequencer #(.ITER_CYCLES(ITER)) dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .flush                       (flush),
    .op_valid                    (op_valid),
    .op_ready                    (op_ready),
    .op_code                     (op_code),
    .exponent_a                  (exponent_a),
    .exponent_b                  (exponent_b),
    .aligned_exponent_a          (aligned_exponent_a),
    .aligned_exponent_b          (aligned_exponent_b),
    .calculation_exponent_select (calculation_exponent_select),
    .calculated_exponent         (calculated_exponent),
    .busy                        (busy),
    .result_valid                (result_valid),
    .result_ready                (result_ready),
    .result_exponent             (result_exponent),
    .result_illegal_op           (result_illegal_op)
  );

  always #5 clk = ~clk;

  // Stand-in for the exponent selecter datapath.
  function automatic logic [9:0] selecter(input calc1::exponent_select s,
                                          input logic [7:0] a, input logic [7:0] b);
    logic [9:0] xa;
    logic [9:0] xb;
    xa = {{2{a[7]}}, a};
    xb = {{2{b[7]}}, b};
    case (s)
      calc1::A:     return xa;
      calc1::B:     return xb;
      calc1::ADD:   return xa + xb;
      calc1::SUB:   return xa - xb;
      calc1::B_SHR: return {3'b000, b[7:1]};
      default:      return 10'h000;
    endcase
  endfunction

  always_comb calculated_exponent = selecter(calculation_exponent_select,
                                             aligned_exponent_a, aligned_exponent_b);

  // Expected result of an op, as plain signed integer arithmetic.
  function automatic logic [9:0] expect_res(input logic [2:0] c,
                                            input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (c)
      3'd0:    r = sa;
      3'd1:    r = sb;
      3'd2:    r = sa + sb;
      3'd3:    r = sa - sb;
      3'd4:    r = int'(b) / 2;
      default: r = sa;
    endcase
    return 10'(r);
  endfunction

  function automatic calc1::exponent_select op_sel(input logic [2:0] c);
    case (c)
      3'd0:    return calc1::A;
      3'd1:    return calc1::B;
      3'd2:    return calc1::ADD;
      3'd3:    return calc1::SUB;
      3'd4:    return calc1::B_SHR;
      default: return calc1::A;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: one op in flight, result due a fixed number of cycles after accept.
  int                    cyc = 0;
  int                    m_due = 0;
  bit                    m_busy = 1'b0;
  bit                    m_have = 1'b0;
  bit                    m_ill = 1'b0;
  logic [9:0]            m_res = 10'd0;
  logic [7:0]            m_a = 8'd0;
  logic [7:0]            m_b = 8'd0;
  logic [2:0]            m_op = 3'd0;
  calc1::exponent_select m_sel = calc1::A;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
      m_have = 1'b0;
      m_ill  = 1'b0;
      m_res  = 10'd0;
      m_a    = 8'd0;
      m_b    = 8'd0;
      m_sel  = calc1::A;
    end else begin
      cyc++;
      if (m_have) begin
        if (flush || result_ready) m_have = 1'b0;
      end else if (m_busy) begin
        if (flush) begin
          m_busy = 1'b0;
        end else if (cyc == m_due) begin
          m_busy = 1'b0;
          m_have = 1'b1;
          m_res  = expect_res(m_op, m_a, m_b);
          m_ill  = (m_op > 3'd4);
        end
      end else if (op_valid && !flush) begin
        m_busy = 1'b1;
        m_op   = op_code;
        m_a    = exponent_a;
        m_b    = exponent_b;
        m_sel  = op_sel(op_code);
        m_due  = cyc + (((op_code == 3'd3) || (op_code == 3'd4)) ? int'(ITER) : 1);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("op_ready", 32'(op_ready), 32'(!(m_busy || m_have)));
    chk("busy", 32'(busy), 32'(m_busy || m_have));
    chk("result_valid", 32'(result_valid), 32'(m_have));
    chk("select", 32'(calculation_exponent_select), 32'(m_sel));
    chk("aligned_a", 32'(aligned_exponent_a), 32'(m_a));
    chk("aligned_b", 32'(aligned_exponent_b), 32'(m_b));
    if (m_have) begin
      chk("result_exponent", 32'(result_exponent), 32'(m_res));
      chk("result_illegal", 32'(result_illegal_op), 32'(m_ill));
    end
  end

  // Present one op; returns just after its accept edge with inputs scrambled.
  task automatic send(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = c; exponent_a = a; exponent_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_code = 3'($urandom); exponent_a = 8'($urandom); exponent_b = 8'($urandom);
  endtask

  // Count cycles from accept to result_valid; optionally pulse op_valid while busy.
  task automatic wait_result(input bit pulse, output int lat, output int iters);
    bit done;
    done = 1'b0; lat = 0; iters = 0;
    while (!done) begin
      @(negedge clk);
      if (result_valid) begin
        done = 1'b1;
      end else begin
        if (busy) iters++;
        lat++;
        if (pulse) begin
          op_valid = (lat % 3 == 1);
          op_code = 3'd2; exponent_a = 8'($urandom); exponent_b = 8'($urandom);
        end
        if (lat >= 300) done = 1'b1;
      end
    end
    op_valid = 1'b0;
  endtask

  // Hold result_ready low for some cycles, then take the result.
  task automatic take_result(input int hold, input logic [9:0] expv);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(result_valid), 32'd1);
      chk("hold_value", 32'(result_exponent), 32'(expv));
    end
    @(posedge clk); #1 result_ready = 1'b1;
    @(posedge clk); #1 result_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_take", 32'(op_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int it;
    int seen;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_select", 32'(calculation_exponent_select), 32'(calc1::A));
    chk("rst_result", 32'(result_exponent), 32'd0);
    chk("rst_illegal", 32'(result_illegal_op), 32'd0);
    reset_n = 1'b1;

    // PASS_A
    send(3'd0, 8'h7F, 8'h00);
    wait_result(1'b0, lat, it);
    chk("pass_a_lat", 32'(lat), 32'd1);
    chk("pass_a_res", 32'(result_exponent), 32'h07F);
    take_result(0, 10'h07F);

    // PASS_B sign-extends b
    send(3'd1, 8'h10, 8'h85);
    wait_result(1'b0, lat, it);
    chk("pass_b_lat", 32'(lat), 32'd1);
    chk("pass_b_res", 32'(result_exponent), 32'h385);
    chk("pass_b_ill", 32'(result_illegal_op), 32'd0);
    take_result(1, 10'h385);

    // DIV with op_valid pulses while busy
    send(3'd3, 8'h80, 8'h7F);
    wait_result(1'b1, lat, it);
    chk("div_lat", 32'(lat), 32'(ITER));
    chk("div_iter_cycles", 32'(it), 32'(ITER));
    chk("div_res", 32'(result_exponent), 32'h301);
    take_result(0, 10'h301);

    // SQRT with a stalled consumer
    send(3'd4, 8'h55, 8'h82);
    wait_result(1'b0, lat, it);
    chk("sqrt_lat", 32'(lat), 32'(ITER));
    chk("sqrt_res", 32'(result_exponent), 32'h041);
    take_result(5, 10'h041);

    // Illegal op code
    send(3'd6, 8'h9C, 8'h11);
    wait_result(1'b0, lat, it);
    chk("illegal_lat", 32'(lat), 32'd1);
    chk("illegal_res", 32'(result_exponent), 32'h39C);
    chk("illegal_flag", 32'(result_illegal_op), 32'd1);
    chk("illegal_select", 32'(calculation_exponent_select), 32'(calc1::A));
    take_result(0, 10'h39C);

    // Flush in ITERATE cycle 3 of a DIV
    send(3'd3, 8'h40, 8'h20);
    @(posedge clk);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_ready", 32'(op_ready), 32'd1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);

    // MUL after flush
    send(3'd2, 8'h05, 8'h03);
    wait_result(1'b0, lat, it);
    chk("mul_lat", 32'(lat), 32'd1);
    chk("mul_res", 32'(result_exponent), 32'h008);
    chk("mul_select", 32'(calculation_exponent_select), 32'(calc1::ADD));
    take_result(0, 10'h008);

    // MUL overflow past 8 bits, then flush and result_ready together in DONE
    send(3'd2, 8'h7F, 8'h7F);
    wait_result(1'b0, lat, it);
    chk("mul_ovf_res", 32'(result_exponent), 32'h0FE);
    @(posedge clk); #1 flush = 1'b1; result_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b0; result_ready = 1'b0;
    @(negedge clk);
    chk("flush_ready_valid", 32'(result_valid), 32'd0);
    chk("flush_ready_busy", 32'(busy), 32'd0);

    // Flush in IDLE blocks an accept
    @(posedge clk); #1 op_valid = 1'b1; op_code = 3'd1; flush = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_accept", 32'(busy), 32'd0);

    // Asynchronous reset mid-DIV with counter at 10
    send(3'd3, 8'h80, 8'h7F);
    repeat (13) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_select", 32'(calculation_exponent_select), 32'(calc1::A));
    chk("midrst_ready", 32'(op_ready), 32'd1);
    chk("midrst_aligned_a", 32'(aligned_exponent_a), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Normal op after reset
    send(3'd1, 8'h00, 8'h3C);
    wait_result(1'b0, lat, it);
    chk("post_rst_res", 32'(result_exponent), 32'h03C);
    take_result(0, 10'h03C);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
